// File: rtl/counter_9999_ctrl.sv
// rtl/counter_9999_ctrl.sv - run/stop/clear 0..9999 counter with prescaled tick (optional debounce: COUNTER_DEBOUNCE_EN)
module counter_9999_ctrl #(
    parameter int DIV_TICK     = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run_stop,
    input  logic        btn_clear,
    input  logic        mode_down,
    output logic [13:0] cnt,
    output logic        running,
    output logic        wrap
);

    localparam int              PW       = $clog2(DIV_TICK);
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV_TICK - 1);
    localparam logic [13:0]     CNT_MAX  = 14'd9999;

    // Elaboration-time guard on the configuration range
    if (DIV_TICK < 2 || DEBOUNCE_CYC < 1) begin : g_bad_cfg
        $error("counter_9999_ctrl: DIV_TICK must be >= 2 and DEBOUNCE_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Bit 0 is the run/stop button, bit 1 the clear button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    level;
    logic [1:0]    prev_q;
    logic [1:0]    evt;
    logic          run_evt;
    logic          clr_evt;

    state_e        state_q;
    logic [PW-1:0] pre_q;
    logic [13:0]   cnt_q;
    logic          running_q;
    logic          wrap_q;

    logic          tick;
    logic [13:0]   cnt_d;
    logic          wrap_d;

    assign btn_raw = {btn_clear, btn_run_stop};

    // Two-stage synchronizer for the asynchronous push buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef COUNTER_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic [1:0]    acc_q;
    logic [DW-1:0] db_cnt_q [2];

    // Accept a new level only after DEBOUNCE_CYC consecutive samples that differ
    // from the accepted one; any sample matching the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == acc_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    acc_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign level = acc_q;
`else
    assign level = sync2_q;
`endif

    // Previous accepted level for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= level;
        end
    end

    assign evt     = level & ~prev_q;
    assign run_evt = evt[0];
    assign clr_evt = evt[1];

    assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

    // Next count value for a tick, in the direction currently selected
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (mode_down) begin
            if (cnt_q == 14'd0) begin
                cnt_d  = CNT_MAX;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 14'd1;
            end
        end else begin
            if (cnt_q >= CNT_MAX) begin
                cnt_d  = 14'd0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 14'd1;
            end
        end
    end

    // Control FSM with prescaler, count register and registered outputs.
    // Clear zeroes the count on the event cycle so a coinciding tick is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_STOP;
            pre_q     <= '0;
            cnt_q     <= 14'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                ST_STOP: begin
                    if (clr_evt) begin
                        state_q   <= ST_CLEAR;
                        cnt_q     <= 14'd0;
                        pre_q     <= '0;
                        running_q <= 1'b0;
                    end else if (run_evt) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_evt) begin
                        state_q   <= ST_CLEAR;
                        cnt_q     <= 14'd0;
                        pre_q     <= '0;
                        running_q <= 1'b0;
                    end else begin
                        if (tick) begin
                            cnt_q  <= cnt_d;
                            wrap_q <= wrap_d;
                            pre_q  <= '0;
                        end else begin
                            pre_q <= pre_q + PW'(1);
                        end
                        if (run_evt) begin
                            state_q   <= ST_STOP;
                            running_q <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_q   <= ST_STOP;
                    cnt_q     <= 14'd0;
                    pre_q     <= '0;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_STOP;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign cnt     = cnt_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_counter_9999_ctrl.sv
// tb/tb_counter_9999_ctrl.sv - directed self-checking bench for counter_9999_ctrl
module tb_counter_9999_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 8;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        btn_run_stop = 1'b0;
    logic        btn_clear    = 1'b0;
    logic        mode_down    = 1'b0;
    logic [13:0] cnt;
    logic        running;
    logic        wrap;

    int errors = 0;
    int checks = 0;

    counter_9999_ctrl #(
        .DIV_TICK     (DIV),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .mode_down    (mode_down),
        .cnt          (cnt),
        .running      (running),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        mode_down    = 1'b0;
        rst          = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_reset_init;
        #2 rst = 1'b0;
        #1;
        checks++; if (cnt !== 14'd0)   begin errors++; $display("FAIL init_cnt: got %0d expected 0", cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL init_running: got %b expected 0", running); end
        checks++; if (wrap !== 1'b0)    begin errors++; $display("FAIL init_wrap: got %b expected 0", wrap); end
        step(2);
        rst = 1'b1;
        step(1);
    endtask

`ifdef COUNTER_DEBOUNCE_EN
    task automatic test_debounce;
        do_reset();
        btn_run_stop = 1'b1;
        step(3 + DB);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL db_run_start: got %b expected 1", running); end
        btn_run_stop = 1'b0;
        step(8);
        checks++; if (cnt !== 14'd2) begin errors++; $display("FAIL db_cnt_before: got %0d expected 2", cnt); end
        for (int k = 0; k < 5; k++) begin
            btn_clear = 1'b1;
            step(3);
            btn_clear = 1'b0;
            step(3);
        end
        checks++; if (cnt !== 14'd9)    begin errors++; $display("FAIL db_bounce_cnt: got %0d expected 9", cnt); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL db_bounce_running: got %b expected 1", running); end
        btn_clear = 1'b1;
        step(2 + DB);
        checks++; if (cnt !== 14'd12)   begin errors++; $display("FAIL db_pre_clear_cnt: got %0d expected 12", cnt); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL db_pre_clear_running: got %b expected 1", running); end
        step(1);
        checks++; if (cnt !== 14'd0)    begin errors++; $display("FAIL db_clear_cnt: got %0d expected 0", cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL db_clear_running: got %b expected 0", running); end
        step(20);
        checks++; if (cnt !== 14'd0)    begin errors++; $display("FAIL db_after_cnt: got %0d expected 0", cnt); end
        btn_clear = 1'b0;
    endtask
`else
    task automatic press_run;
        btn_run_stop = 1'b1;
        step(1);
        btn_run_stop = 1'b0;
        step(2);
    endtask

    task automatic test_run_stop;
        btn_run_stop = 1'b1;
        step(1);
        btn_run_stop = 1'b0;
        step(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rs_running_edge2: got %b expected 0", running); end
        step(1);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL rs_running_edge3: got %b expected 1", running); end
        step(3);
        checks++; if (cnt !== 14'd0) begin errors++; $display("FAIL rs_cnt_before_tick: got %0d expected 0", cnt); end
        step(1);
        checks++; if (cnt !== 14'd1) begin errors++; $display("FAIL rs_first_tick: got %0d expected 1", cnt); end
        step(16);
        checks++; if (cnt !== 14'd5) begin errors++; $display("FAIL rs_cnt5: got %0d expected 5", cnt); end
        press_run();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rs_stopped: got %b expected 0", running); end
        step(10);
        checks++; if (cnt !== 14'd5) begin errors++; $display("FAIL rs_hold: got %0d expected 5", cnt); end
        press_run();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL rs_resumed: got %b expected 1", running); end
        checks++; if (cnt !== 14'd5)    begin errors++; $display("FAIL rs_resume_cnt: got %0d expected 5", cnt); end
        step(1);
        checks++; if (cnt !== 14'd6) begin errors++; $display("FAIL rs_partial_period: got %0d expected 6", cnt); end
    endtask

    task automatic test_reset_mid_run;
        step(124);
        checks++; if (cnt !== 14'd37) begin errors++; $display("FAIL mr_cnt37: got %0d expected 37", cnt); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cnt !== 14'd0)    begin errors++; $display("FAIL mr_async_cnt: got %0d expected 0", cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL mr_async_running: got %b expected 0", running); end
        checks++; if (wrap !== 1'b0)    begin errors++; $display("FAIL mr_async_wrap: got %b expected 0", wrap); end
        #1 rst = 1'b1;
        step(10);
        checks++; if (cnt !== 14'd0)    begin errors++; $display("FAIL mr_after_cnt: got %0d expected 0", cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL mr_after_running: got %b expected 0", running); end
    endtask

    task automatic test_wrap;
        do_reset();
        mode_down = 1'b1;
        press_run();
        step(3);
        checks++; if (cnt !== 14'd0 || wrap !== 1'b0) begin errors++; $display("FAIL wr_pre_down: got cnt=%0d wrap=%b expected 0/0", cnt, wrap); end
        step(1);
        checks++; if (cnt !== 14'd9999) begin errors++; $display("FAIL wr_down_cnt: got %0d expected 9999", cnt); end
        checks++; if (wrap !== 1'b1)     begin errors++; $display("FAIL wr_down_wrap: got %b expected 1", wrap); end
        step(1);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wr_down_wrap_pulse: got %b expected 0", wrap); end
        step(3);
        checks++; if (cnt !== 14'd9998) begin errors++; $display("FAIL wr_down_step: got %0d expected 9998", cnt); end
        mode_down = 1'b0;
        step(4);
        checks++; if (cnt !== 14'd9999 || wrap !== 1'b0) begin errors++; $display("FAIL wr_up_9999: got cnt=%0d wrap=%b expected 9999/0", cnt, wrap); end
        step(4);
        checks++; if (cnt !== 14'd0) begin errors++; $display("FAIL wr_up_cnt: got %0d expected 0", cnt); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wr_up_wrap: got %b expected 1", wrap); end
        step(1);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wr_up_wrap_pulse: got %b expected 0", wrap); end
    endtask

    task automatic test_clear_priority;
        do_reset();
        press_run();
        step(492);
        checks++; if (cnt !== 14'd123) begin errors++; $display("FAIL cp_cnt123: got %0d expected 123", cnt); end
        btn_run_stop = 1'b1;
        btn_clear    = 1'b1;
        step(1);
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        step(2);
        checks++; if (cnt !== 14'd0)    begin errors++; $display("FAIL cp_cnt: got %0d expected 0", cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL cp_running: got %b expected 0", running); end
        step(11);
        checks++; if (cnt !== 14'd0 || running !== 1'b0) begin errors++; $display("FAIL cp_stop: got cnt=%0d running=%b expected 0/0", cnt, running); end
        press_run();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL cp_restart: got %b expected 1", running); end
        step(3);
        checks++; if (cnt !== 14'd0) begin errors++; $display("FAIL cp_pre_cleared: got %0d expected 0", cnt); end
        step(1);
        checks++; if (cnt !== 14'd1) begin errors++; $display("FAIL cp_first_tick: got %0d expected 1", cnt); end
    endtask

    task automatic test_tick_collision;
        do_reset();
        press_run();
        step(37);
        checks++; if (cnt !== 14'd9) begin errors++; $display("FAIL tc_cnt9: got %0d expected 9", cnt); end
        press_run();
        checks++; if (cnt !== 14'd10)   begin errors++; $display("FAIL tc_cnt10: got %0d expected 10", cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL tc_running: got %b expected 0", running); end
        step(8);
        checks++; if (cnt !== 14'd10) begin errors++; $display("FAIL tc_hold: got %0d expected 10", cnt); end
    endtask

    task automatic test_bounce_no_debounce;
        do_reset();
        press_run();
        step(8);
        checks++; if (cnt !== 14'd2) begin errors++; $display("FAIL nb_cnt2: got %0d expected 2", cnt); end
        btn_clear = 1'b1;
        step(3);
        checks++; if (cnt !== 14'd0 || running !== 1'b0) begin errors++; $display("FAIL nb_first_clear: got cnt=%0d running=%b expected 0/0", cnt, running); end
        btn_clear = 1'b0;
        step(3);
        for (int k = 0; k < 4; k++) begin
            btn_clear = 1'b1;
            step(3);
            btn_clear = 1'b0;
            step(3);
        end
        btn_clear = 1'b1;
        step(6);
        checks++; if (cnt !== 14'd0 || running !== 1'b0) begin errors++; $display("FAIL nb_end: got cnt=%0d running=%b expected 0/0", cnt, running); end
        btn_clear = 1'b0;
    endtask
`endif

    initial begin
        test_reset_init();
`ifdef COUNTER_DEBOUNCE_EN
        test_debounce();
`else
        test_run_stop();
        test_reset_mid_run();
        test_wrap();
        test_clear_priority();
        test_tick_collision();
        test_bounce_no_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
